// File: rtl/serial_addsub_if.sv
// Request/response bundle for the digit-serial adder/subtractor.
// The master side drives the operands and start; the slave side returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Purpose: WIDTH-bit add/subtract computed DIGIT bits per clock through a registered-carry ripple slice.
// Latency: start accepted at edge k, done pulses and sum/cout/ovf are valid after edge k+WIDTH/DIGIT.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave io
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic             sub_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   cc;
    logic [WIDTH-1:0] res_next;

    // One digit of full adders; cc[DIGIT-1] is the carry into the operand MSB on the last step.
    always_comb begin
        a_dig = a_sr[DIGIT-1:0];
        b_dig = b_sr[DIGIT-1:0] ^ {DIGIT{sub_q}};
        cc    = '0;
        cc[0] = carry;
        dsum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_dig[i] ^ b_dig[i] ^ cc[i];
            cc[i+1]  = (a_dig[i] & b_dig[i]) | (cc[i] & (a_dig[i] ^ b_dig[i]));
        end
        res_next = (res_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (io.start) begin
                        a_sr   <= io.a;
                        b_sr   <= io.b;
                        sub_q  <= io.sub;
                        // Subtract runs as a + ~b + ~borrow_in.
                        carry  <= io.cin ^ io.sub;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    carry  <= cc[DIGIT];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(STEPS - 1)) begin
                        sum_q  <= res_next;
                        cout_q <= cc[DIGIT];
                        ovf_q  <= cc[DIGIT] ^ cc[DIGIT-1];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.sum  = sum_q;
    assign io.cout = cout_q;
    assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised checks of serial_addsub in bit-serial, nibble-serial and single-step configurations.
module tb_serial_addsub;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_addsub_if #(.WIDTH(8))  if8 ();
    serial_addsub_if #(.WIDTH(16)) if16 ();
    serial_addsub_if #(.WIDTH(8))  ifw ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .io(if8.slave));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .io(if16.slave));
    serial_addsub #(.WIDTH(8),  .DIGIT(8)) dutw  (.clk(clk), .rst_n(rst_n), .io(ifw.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {cout, ovf, sum} for an 8-bit add/sub.
    function automatic logic [9:0] gold8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
        logic [7:0] bx;
        logic       ci;
        logic [8:0] full;
        logic [7:0] low;
        bx   = s ? ~b : b;
        ci   = s ? ~c : c;
        full = {1'b0, a} + {1'b0, bx} + {8'd0, ci};
        low  = {1'b0, a[6:0]} + {1'b0, bx[6:0]} + {7'd0, ci};
        return {full[8], low[7] ^ full[8], full[7:0]};
    endfunction

    task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        if8.sub   = s;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = c;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (if8.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        go8(s, a, b, c);
        chk({tag, "_busy"}, 32'(if8.busy), 32'd1);
        wait8(n);
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(if8.sum), 32'(es));
        chk({tag, "_cout"}, 32'(if8.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(if8.ovf), 32'(eo));
        chk({tag, "_nbusy"}, 32'(if8.busy), 32'd0);
    endtask

    initial begin
        int          n;
        int          pulses;
        int          first_at;
        logic        rs;
        logic        rc;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [9:0]  exp;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {if8.start, if8.sub, if8.a, if8.b, if8.cin}     = '0;
        {if16.start, if16.sub, if16.a, if16.b, if16.cin} = '0;
        {ifw.start, ifw.sub, ifw.a, ifw.b, ifw.cin}     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_sum",  32'(if8.sum),  32'd0);
        chk("rst_cout", 32'(if8.cout), 32'd0);
        chk("rst_ovf",  32'(if8.ovf),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("add5a3c",  1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("idle_hold_sum", 32'(if8.sum), 32'h96);
        chk("idle_done", 32'(if8.done), 32'd0);
        run8("addff01",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add7f00c", 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        run8("sub1020",  1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0);
        run8("sub8001",  1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        run8("sub0505b", 1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0);

        // Start pulsed mid-run must not disturb the operation.
        go8(1'b0, 8'h5A, 8'h3C, 1'b0);
        @(posedge clk);
        @(negedge clk);
        if8.a     = 8'h01;
        if8.b     = 8'h01;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        pulses   = 0;
        first_at = 0;
        for (int i = 3; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (if8.done) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        chk("ign_pulses", 32'(pulses), 32'd1);
        chk("ign_lat", 32'(first_at), 32'd8);
        chk("ign_sum", 32'(if8.sum), 32'h96);
        chk("ign_busy", 32'(if8.busy), 32'd0);

        // Start in the DONE cycle is accepted back-to-back.
        go8(1'b0, 8'h5A, 8'h3C, 1'b0);
        wait8(n);
        chk("b2b_first_lat", 32'(n), 32'd8);
        if8.a     = 8'h11;
        if8.b     = 8'h22;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        chk("b2b_done_drop", 32'(if8.done), 32'd0);
        chk("b2b_busy_rise", 32'(if8.busy), 32'd1);
        chk("b2b_sum_hold", 32'(if8.sum), 32'h96);
        wait8(n);
        chk("b2b_lat", 32'(n), 32'd8);
        chk("b2b_sum", 32'(if8.sum), 32'h33);

        // Asynchronous reset mid-run.
        go8(1'b0, 8'h5A, 8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(if8.busy), 32'd0);
        chk("arst_done", 32'(if8.done), 32'd0);
        chk("arst_sum",  32'(if8.sum),  32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (if8.done) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        chk("arst_idle", 32'(if8.busy), 32'd0);

        // Nibble-serial 16-bit.
        @(negedge clk);
        if16.a     = 16'hFFFF;
        if16.b     = 16'h0001;
        if16.start = 1'b1;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (if16.done) begin
                n = i;
                break;
            end
        end
        chk("w16_lat",  32'(n), 32'd4);
        chk("w16_sum",  32'(if16.sum), 32'h0000);
        chk("w16_cout", 32'(if16.cout), 32'd1);
        chk("w16_ovf",  32'(if16.ovf), 32'd0);

        // Single-step 8-bit against the golden model.
        for (int i = 0; i < 1000; i++) begin
            rs = 1'($urandom_range(1));
            rc = 1'($urandom_range(1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp = gold8(rs, ra, rb, rc);
            @(negedge clk);
            ifw.sub   = rs;
            ifw.a     = ra;
            ifw.b     = rb;
            ifw.cin   = rc;
            ifw.start = 1'b1;
            @(posedge clk);
            #1;
            ifw.start = 1'b0;
            @(posedge clk);
            #1;
            chk("rand_w8d8", 32'({ifw.done, ifw.cout, ifw.ovf, ifw.sum}), 32'({1'b1, exp}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor, successor to the combinational half/full adder cells. It processes DIGIT bits per clock through an internal DIGIT-wide full-adder chain, keeping a registered carry between digits. It uses a start/busy/done handshake and has a selectable subtract mode, carry/borrow in and a signed-overflow flag. It is intended for area-constrained datapaths where a WIDTH-bit ripple adder is too large.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥2.
DIGIT, 1, bits processed per clock; must divide WIDTH. STEPS = WIDTH/DIGIT.

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; accepted on a rising edge when busy=0
sub  input  1  0 = add, 1 = subtract; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in (add) or borrow-in (sub); sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  registered result
cout  output  1  add: carry-out; sub: 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry and counter all 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter 0..STEPS-1.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Acceptance:
  - On an edge where start=1 and state is IDLE or DONE, latch a, b, sub and cin.
  - Internal carry = cin for add, ~cin for sub.
  - Counter clears and state becomes RUN.
  - A start in DONE gives back-to-back operation: done drops and busy rises on the same edge.
- start while busy=1 is ignored, with no effect on the operation in flight.
- Each RUN edge:
  - Operand B digit is inverted when sub=1.
  - Add the low DIGIT bits of the A and B shift registers plus the carry.
  - Shift the result digit into the MSB end of the result shift register.
  - Update the carry and shift both operand registers right by DIGIT.
  - Increment the counter.
- On the RUN edge with counter=STEPS-1 (the STEPS-th RUN edge after acceptance):
  - State goes to DONE.
  - Load sum from the completed result register.
  - cout = final carry.
  - ovf = (carry into MSB) XOR (carry out of MSB).
  - done=1 for the following cycle.
- Latency: start accepted at edge k; done=1 and results valid after edge k+STEPS. The DONE cycle then returns to IDLE on the next edge unless a new start is accepted.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: sum = (a − b − cin) mod 2^WIDTH, cout = ~borrow, computed as a + ~b + ~cin.
- sum, cout and ovf change only on the completion edge or reset. They hold their values through IDLE and through subsequent RUN cycles until the next completion.
- Reset mid-operation: the operation is abandoned immediately and all outputs take their reset values. No done is produced.
- Input changes on a, b, sub and cin after acceptance have no effect.

Test Plan:
- WIDTH=8, DIGIT=1, add a=0x5A, b=0x3C, cin=0 → busy high 8 cycles, done after edge k+8, sum=0x96, cout=0, ovf=1.
- Add a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Add a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, ovf=1.
- Sub a=0x10, b=0x20, cin=0 → sum=0xF0, cout=0, ovf=0. Sub a=0x80, b=0x01, cin=0 → sum=0x7F, cout=1, ovf=1. Sub a=0x05, b=0x05, cin=1 → sum=0xFF, cout=0.
- Pulse start with a=0x01, b=0x01 during cycle 3 of a 0x5A+0x3C run → ignored; result still 0x96, exactly one done pulse. Start asserted in the DONE cycle → new op accepted, next done 8 edges later.
- Assert rst_n=0 asynchronously (mid-cycle) 4 cycles into a run → busy, done and sum go 0 immediately. After release, no done appears until a new start.
- WIDTH=16, DIGIT=4, add a=0xFFFF, b=0x0001 → done after 4 edges, sum=0x0000, cout=1. Compare WIDTH=8, DIGIT=8 against the golden model over 1000 random add/sub vectors.
